uart_packet_tx: RTL and testbench

Parametrised UART transmitter that captures a multi-byte packet and serialises it as a sequence of standard UART frames on a single `tx` line. Each frame is:
- start bit;
- DATA_BITS data bits, LSB first;
- optional parity bit;
- STOP_BITS stop bits.

Byte 0 (packet LSBs) is sent first. The block sits between the packet-assembly logic and the board UART pin and replaces the parallel 11-bit frame output with a real baud-timed serial line.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_packet_tx_if.sv | 38 +++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_packet_tx.sv | 197 +++++++++++++++++++
 tb/tb_uart_packet_tx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types, line levels and the parity helper for the packet UART transmitter.
// Contents:
//   uart_tx_state_t   - transmit FSM state encoding
//   UART_IDLE_LEVEL   - line level while idle / during stop bits
//   UART_START_LEVEL  - line level of the start bit
//   uart_parity()     - parity of up to 9 data bits, odd flag selects odd parity
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic uart_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_packet_tx_if.sv
// Packet-side bus of the UART transmitter.
// Signals:
//   packet       - PACKET_BYTES words of DATA_BITS, word 0 in the LSBs
//   data_ready   - start request (master -> slave)
//   data_clear   - synchronous abort (master -> slave)
//   tx           - serial line, idle high (slave -> master)
//   busy         - packet in flight (slave -> master)
//   byte_index   - word currently on the line (slave -> master)
//   byte_done    - one-cycle pulse at the end of each frame (slave -> master)
//   packet_done  - one-cycle pulse at the end of the last frame (slave -> master)
// Modports: master = packet source, slave = transmitter.
interface uart_packet_tx_if #(
  parameter int unsigned PACKET_BYTES = 4,
  parameter int unsigned DATA_BITS    = 8
);

  localparam int unsigned IDX_W = $clog2(PACKET_BYTES) + 1;

  logic [PACKET_BYTES*DATA_BITS-1:0] packet;
  logic                              data_ready;
  logic                              data_clear;
  logic                              tx;
  logic                              busy;
  logic [IDX_W-1:0]                  byte_index;
  logic                              byte_done;
  logic                              packet_done;

  modport master (
    output packet, data_ready, data_clear,
    input  tx, busy, byte_index, byte_done, packet_done
  );

  modport slave (
    input  packet, data_ready, data_clear,
    output tx, busy, byte_index, byte_done, packet_done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is a registered one-cycle pulse every CLKS_PER_BIT cycles.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restarts the period (counter back to 0, no tick)
//   tick      - high during the last cycle of each bit period
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;

  // tick is registered one cycle early so it coincides with cnt_q == CNT_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (clear || (cnt_q == CNT_LAST)) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      tick  <= (cnt_q == CNT_PRE_LAST);
    end
  end

endmodule

// File: rtl/uart_packet_tx.sv
// Packet UART transmitter: latches a multi-word packet and sends it as back-to-back
// UART frames (start, DATA_BITS LSB first, optional parity, STOP_BITS stop), word 0 first.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - uart_packet_tx_if.slave (packet, data_ready, data_clear in;
//               tx, busy, byte_index, byte_done, packet_done out, all registered)
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data bits
// (even parity, or odd when PARITY_ODD=1).
module uart_packet_tx
  import uart_pkg::*;
#(
  parameter int unsigned PACKET_BYTES = 4,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  uart_packet_tx_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(PACKET_BYTES) + 1;
  localparam int unsigned PKT_W = PACKET_BYTES * DATA_BITS;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PACKET_BYTES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  uart_tx_state_t   state_q, state_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             byte_done_q, byte_done_d;
  logic             packet_done_q, packet_done_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             stop_cnt_q, stop_cnt_d;

  logic             tick;
  logic             baud_clear_c;
  logic [DATA_BITS-1:0] word_c;

  // The bit timer is held at zero while idle so the start bit gets a full period.
  assign baud_clear_c = (state_q == IDLE) || bus.data_clear;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear_c),
    .tick (tick)
  );

  // The latched packet is shifted down one word per frame, so the current word is always at the bottom.
  assign word_c = pkt_q[DATA_BITS-1:0];

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tx_q          <= UART_IDLE_LEVEL;
      busy_q        <= 1'b0;
      idx_q         <= '0;
      byte_done_q   <= 1'b0;
      packet_done_q <= 1'b0;
      pkt_q         <= '0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      stop_cnt_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      idx_q         <= idx_d;
      byte_done_q   <= byte_done_d;
      packet_done_q <= packet_done_d;
      pkt_q         <= pkt_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      stop_cnt_q    <= stop_cnt_d;
    end
  end

  // Next-state and next-output logic; every transition happens on a bit-period tick.
  always_comb begin
    state_d       = state_q;
    tx_d          = tx_q;
    busy_d        = busy_q;
    idx_d         = idx_q;
    byte_done_d   = 1'b0;
    packet_done_d = 1'b0;
    pkt_d         = pkt_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    stop_cnt_d    = stop_cnt_q;

    if (bus.data_clear) begin
      // Abort wins over everything, including a same-cycle start request.
      state_d    = IDLE;
      tx_d       = UART_IDLE_LEVEL;
      busy_d     = 1'b0;
      idx_d      = '0;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.data_ready) begin
            state_d = START;
            tx_d    = UART_START_LEVEL;
            busy_d  = 1'b1;
            idx_d   = '0;
            pkt_d   = bus.packet;
          end
        end

        START: begin
          if (tick) begin
            state_d   = DATA;
            tx_d      = word_c[0];
            shreg_d   = word_c >> 1;
            bit_cnt_d = '0;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
              tx_d    = uart_parity(9'(word_c), 1'(PARITY_ODD));
`else
              state_d    = STOP;
              tx_d       = UART_IDLE_LEVEL;
              stop_cnt_d = 1'b0;
`endif
            end else begin
              tx_d      = shreg_q[0];
              shreg_d   = shreg_q >> 1;
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_d    = STOP;
            tx_d       = UART_IDLE_LEVEL;
            stop_cnt_d = 1'b0;
          end
        end
`endif

        STOP: begin
          if (tick) begin
            if (stop_cnt_q == LAST_STOP) begin
              byte_done_d = 1'b1;
              if (idx_q < LAST_IDX) begin
                // Next frame starts immediately, no idle gap between words.
                state_d = START;
                tx_d    = UART_START_LEVEL;
                idx_d   = idx_q + IDX_W'(1);
                pkt_d   = pkt_q >> DATA_BITS;
              end else begin
                state_d       = IDLE;
                packet_done_d = 1'b1;
                busy_d        = 1'b0;
                idx_d         = '0;
              end
            end else begin
              stop_cnt_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          tx_d    = UART_IDLE_LEVEL;
          busy_d  = 1'b0;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign bus.tx          = tx_q;
  assign bus.busy        = busy_q;
  assign bus.byte_index  = idx_q;
  assign bus.byte_done   = byte_done_q;
  assign bus.packet_done = packet_done_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Self-checking bench for uart_packet_tx: 2-word packets, 8 data bits, 4 clocks per bit.
// With UART_TX_PARITY_EN the frame has even parity and one stop bit; without it, two stop bits.
module tb_uart_packet_tx;

  localparam int PB  = 2;
  localparam int DB  = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int SB = 1;
  localparam int P  = 1;
`else
  localparam int SB = 2;
  localparam int P  = 0;
`endif
  localparam int ODD        = 0;
  localparam int FRAME_BITS = 1 + DB + P + SB;
  localparam int FC         = CPB * FRAME_BITS;
  localparam int PKT_CYC    = PB * FC;
  localparam int IDX_W      = $clog2(PB) + 1;
  localparam int PKW        = PB * DB;
  localparam int VW         = IDX_W + 4;

  localparam logic [VW-1:0] IDLE_V = {1'b1, 3'b000, {IDX_W{1'b0}}};

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_packet_tx_if #(.PACKET_BYTES(PB), .DATA_BITS(DB)) bus ();

  uart_packet_tx #(
    .PACKET_BYTES(PB),
    .DATA_BITS   (DB),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB),
    .PARITY_ODD  (ODD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit model_q[$];

  // Line levels of a whole packet, one entry per bit period.
  function automatic void build_model(input logic [PKW-1:0] pkt);
    model_q.delete();
    for (int b = 0; b < PB; b++) begin
      logic [DB-1:0] w;
      w = pkt[b*DB +: DB];
      model_q.push_back(1'b0);
      for (int i = 0; i < DB; i++) model_q.push_back(w[i]);
      if (P == 1) model_q.push_back(1'(($countones(w) + ODD) % 2));
      for (int s = 0; s < SB; s++) model_q.push_back(1'b1);
    end
  endfunction

  // Expected {tx, busy, byte_done, packet_done, byte_index} k cycles after acceptance.
  function automatic logic [VW-1:0] exp_at(input int k);
    logic t, b, bd, pd;
    logic [IDX_W-1:0] ix;
    if (k < PKT_CYC) begin
      t  = model_q[k / CPB];
      b  = 1'b1;
      ix = IDX_W'(k / FC);
    end else begin
      t  = 1'b1;
      b  = 1'b0;
      ix = '0;
    end
    bd = (k > 0) && (k % FC == 0);
    pd = (k == PKT_CYC);
    return {t, b, bd, pd, ix};
  endfunction

  function automatic logic [VW-1:0] obs();
    return {bus.tx, bus.busy, bus.byte_done, bus.packet_done, bus.byte_index};
  endfunction

  task automatic start_packet(input logic [PKW-1:0] pkt);
    @(negedge clk);
    bus.packet     = pkt;
    bus.data_ready = 1'b1;
    bus.data_clear = 1'b0;
  endtask

  // Checks a full packet from the acceptance edge through the packet_done cycle.
  task automatic check_packet(input logic [PKW-1:0] pkt, input bit keep_ready,
                              input logic [PKW-1:0] next_pkt, input string name);
    logic [VW-1:0] got_v, exp_v;
    build_model(pkt);
    for (int k = 0; k <= PKT_CYC; k++) begin
      @(negedge clk);
      got_v = obs();
      exp_v = exp_at(k);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL %s cycle %0d: tx/busy/bd/pd/idx got %b required %b", name, k, got_v, exp_v);
      end
      if (k < PKT_CYC) begin
        bus.packet     = PKW'($urandom);
        bus.data_ready = keep_ready ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
        bus.packet     = next_pkt;
        bus.data_ready = keep_ready;
      end
    end
  endtask

  task automatic check_idle(input int cycles, input string name);
    logic [VW-1:0] got_v;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      got_v = obs();
      n_cmp++;
      if (got_v !== IDLE_V) begin
        n_err++;
        $display("FAIL %s idle cycle %0d: tx/busy/bd/pd/idx got %b required %b", name, k, got_v, IDLE_V);
      end
    end
  endtask

  task automatic test_reset();
    logic [VW-1:0] got_v;
    rst = 1'b1;
    bus.packet = '0;
    bus.data_ready = 1'b0;
    bus.data_clear = 1'b0;
    repeat (3) @(negedge clk);
    got_v = obs();
    n_cmp++;
    if (got_v !== IDLE_V) begin
      n_err++;
      $display("FAIL reset_state: got %b required %b", got_v, IDLE_V);
    end
    rst = 1'b0;
    check_idle(100, "post_reset");
  endtask

  task automatic test_known_packet();
    start_packet(16'hA503);
    check_packet(16'hA503, 1'b0, '0, "pkt_a503");
  endtask

  task automatic test_random_packets();
    logic [PKW-1:0] p;
    for (int i = 0; i < 4; i++) begin
      p = PKW'($urandom);
      start_packet(p);
      check_packet(p, 1'b0, '0, $sformatf("rand%0d", i));
    end
  endtask

  task automatic run_clear(input logic [PKW-1:0] pkt, input int clr_cyc, input string name);
    logic [VW-1:0] got_v, exp_v;
    build_model(pkt);
    start_packet(pkt);
    for (int k = 0; k <= clr_cyc; k++) begin
      @(negedge clk);
      got_v = obs();
      exp_v = exp_at(k);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL %s cycle %0d: tx/busy/bd/pd/idx got %b required %b", name, k, got_v, exp_v);
      end
      bus.data_ready = 1'b0;
      bus.packet     = PKW'($urandom);
    end
    bus.data_clear = 1'b1;
    @(negedge clk);
    bus.data_clear = 1'b0;
    got_v = obs();
    n_cmp++;
    if (got_v !== IDLE_V) begin
      n_err++;
      $display("FAIL %s after_clear: got %b required %b", name, got_v, IDLE_V);
    end
    check_idle(30, name);
  endtask

  task automatic test_clear();
    run_clear(16'hA503, 20, "clear_c20");
    run_clear(PKW'($urandom), int'($urandom_range(0, PKT_CYC - 1)), "clear_rand");
    // Clear and start request together: nothing is accepted.
    @(negedge clk);
    bus.data_ready = 1'b1;
    bus.data_clear = 1'b1;
    bus.packet     = 16'h1234;
    @(negedge clk);
    bus.data_ready = 1'b0;
    bus.data_clear = 1'b0;
    check_idle(10, "clear_and_ready");
  endtask

  task automatic test_back_to_back();
    logic [PKW-1:0] p2, p3;
    p2 = PKW'($urandom);
    p3 = PKW'($urandom);
    start_packet(16'h00FF);
    check_packet(16'h00FF, 1'b1, p2, "b2b_0");
    check_packet(p2, 1'b1, p3, "b2b_1");
    check_packet(p3, 1'b0, '0, "b2b_2");
    check_idle(10, "b2b_end");
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] got_v, exp_v;
    build_model(16'h0000);
    start_packet(16'h0000);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      got_v = obs();
      exp_v = exp_at(k);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL rst_mid cycle %0d: got %b required %b", k, got_v, exp_v);
      end
      bus.data_ready = 1'b0;
    end
    rst = 1'b1;
    #1;
    got_v = obs();
    n_cmp++;
    if (got_v !== IDLE_V) begin
      n_err++;
      $display("FAIL rst_mid async: got %b required %b", got_v, IDLE_V);
    end
    @(negedge clk);
    rst = 1'b0;
    check_idle(20, "rst_mid_after");
  endtask

  initial begin
    test_reset();
    test_known_packet();
    test_random_packets();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
